align_stream_ctrl: RTL and testbench



---
 rtl/align_stream_ctrl.sv | 152 +++++++++++++++
 tb/tb_align_stream_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/align_stream_ctrl.sv
// Alignment controller: turns unaligned source words (start offset + byte length)
// into a packed, byte-0-aligned output stream with keep/last, valid/ready both sides.
module align_stream_ctrl #(
  parameter  int DATA_WIDTH = 64,
  parameter  int LEN_WIDTH  = 16,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int OFF_WIDTH  = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OFF_WIDTH-1:0]  cmd_offset,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NB-1:0]         out_keep,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  localparam logic [LEN_WIDTH-1:0] NB_LEN  = LEN_WIDTH'(NB);
  localparam logic [OFF_WIDTH:0]   NB_N    = (OFF_WIDTH+1)'(NB);
  localparam logic [OFF_WIDTH+1:0] NB_SPAN = (OFF_WIDTH+2)'(NB);

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] hold;
  logic [OFF_WIDTH-1:0]  off;
  logic [LEN_WIDTH-1:0]  in_left, out_left, bytes_left;

  logic                  cmd_accept, out_free, load_out;
  logic                  needs_next, next_fits;
  logic [LEN_WIDTH:0]    cmd_in_span, cmd_out_span;
  logic [LEN_WIDTH-1:0]  bytes_after;
  logic [OFF_WIDTH:0]    cur_n, next_n, inv_off;
  logic [DATA_WIDTH-1:0] stream_word, drain_word, load_word, load_masked;
  logic [NB-1:0]         keep_mask;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cmd_accept = cmd_valid && (cmd_len != '0);
  assign out_free   = !out_valid || out_ready;

  // Word counts for the command: ceil((off+len)/NB) in, ceil(len/NB) out
  assign cmd_in_span  = {1'b0, cmd_len} + (LEN_WIDTH+1)'(cmd_offset) + (LEN_WIDTH+1)'(NB-1);
  assign cmd_out_span = {1'b0, cmd_len} + (LEN_WIDTH+1)'(NB-1);

  assign bytes_after = (bytes_left > NB_LEN) ? (bytes_left - NB_LEN) : '0;
  assign cur_n       = (bytes_left  >= NB_LEN) ? NB_N : bytes_left[OFF_WIDTH:0];
  assign next_n      = (bytes_after >= NB_LEN) ? NB_N : bytes_after[OFF_WIDTH:0];

  // The current output word spills into the next source word when off+n exceeds NB
  assign needs_next = ((OFF_WIDTH+2)'(off) + (OFF_WIDTH+2)'(cur_n))  >  NB_SPAN;
  assign next_fits  = ((OFF_WIDTH+2)'(off) + (OFF_WIDTH+2)'(next_n)) <= NB_SPAN;

  assign inv_off     = NB_N - {1'b0, off};
  assign drain_word  = hold >> {off, 3'b000};
  assign stream_word = drain_word | (in_data << {inv_off, 3'b000});
  assign load_word   = (state == STREAM) ? stream_word : drain_word;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      assign keep_mask[gi] = (cur_n > (OFF_WIDTH+1)'(gi));
      assign load_masked[gi*8 +: 8] = keep_mask[gi] ? load_word[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load_out   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_accept) state_next = PRIME;
      end
      PRIME: begin
        in_ready = out_free && (in_left != '0);
        if (in_valid && in_ready) state_next = needs_next ? STREAM : DRAIN;
      end
      STREAM: begin
        in_ready = out_free && (in_left != '0);
        if (in_valid && in_ready) begin
          load_out = 1'b1;
          if ((out_left == LEN_WIDTH'(1)) || next_fits) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_free) begin
          // Hold the final word until it is taken so cmd_ready follows out_last
          if (out_left == '0) begin
            state_next = IDLE;
          end else begin
            load_out = 1'b1;
            if ((off == '0) && (in_left != '0)) state_next = PRIME;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      off        <= '0;
      in_left    <= '0;
      out_left   <= '0;
      bytes_left <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if ((state == IDLE) && cmd_accept) begin
        off        <= cmd_offset;
        bytes_left <= cmd_len;
        in_left    <= LEN_WIDTH'(cmd_in_span >> OFF_WIDTH);
        out_left   <= LEN_WIDTH'(cmd_out_span >> OFF_WIDTH);
      end
      if (in_valid && in_ready) begin
        hold    <= in_data;
        in_left <= in_left - LEN_WIDTH'(1);
      end
      if (load_out) begin
        out_data   <= load_masked;
        out_keep   <= keep_mask;
        out_last   <= (out_left == LEN_WIDTH'(1));
        out_valid  <= 1'b1;
        out_left   <= out_left - LEN_WIDTH'(1);
        bytes_left <= bytes_after;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_align_stream_ctrl.sv
// Bench for align_stream_ctrl: directed and randomized transfers compared against a
// byte-stream reference model, with throttling, stall-stability and reset checks.
module tb_align_stream_ctrl;
  localparam int DW = 64;
  localparam int NB = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_offset;
  logic [LW-1:0] cmd_len;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_keep;
  logic          out_last, busy;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] src[$];
  logic [DW-1:0] got_data[$];
  logic [NB-1:0] got_keep[$];
  logic          got_last[$];
  int            n_in;

  always #5 clk = ~clk;

  align_stream_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_offset(cmd_offset), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the transfer is the byte stream starting at offset off
  function automatic logic [7:0] src_byte(input int pos);
    logic [63:0] w;
    w = src[pos / NB];
    return w[(pos % NB)*8 +: 8];
  endfunction

  function automatic logic [63:0] exp_word(input int off, input int len, input int k);
    logic [63:0] r = '0;
    for (int j = 0; j < NB; j++)
      if (NB*k + j < len) r[j*8 +: 8] = src_byte(off + NB*k + j);
    return r;
  endfunction

  function automatic logic [7:0] exp_keep(input int len, input int k);
    logic [7:0] r = '0;
    for (int j = 0; j < NB; j++) r[j] = (NB*k + j < len);
    return r;
  endfunction

  task automatic run_xfer(input int off, input int len, input int in_pct, input int out_pct,
                          input int max_out, input int span_exp, input bit rnd);
    int iw = (off + len + NB - 1) / NB;
    int ow = (len + NB - 1) / NB;
    int first_in = -1;
    int last_out = -1;
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [63:0] pd;
    logic [7:0] pk;
    logic pl;
    logic [63:0] w;
    src.delete(); got_data.delete(); got_keep.delete(); got_last.delete();
    n_in = 0;
    for (int wi = 0; wi < iw + 2; wi++) begin
      if (rnd) w = {$urandom, $urandom};
      else for (int b = 0; b < NB; b++) w[b*8 +: 8] = 8'(NB*wi + b);
      src.push_back(w);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_offset = 3'(off); cmd_len = LW'(len);
    #1;
    check("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (stalled) begin
        check("stall_data", out_data, pd);
        check("stall_keep", out_keep, pk);
        check("stall_last", out_last, pl);
      end
      in_valid  = ($urandom_range(99) < in_pct) && (n_in < src.size());
      in_data   = (n_in < src.size()) ? src[n_in] : '0;
      out_ready = ($urandom_range(99) < out_pct);
      #1;
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (n_in >= iw) check("no_extra_in", in_ready, 0);
      stalled = out_valid && !out_ready;
      pd = out_data; pk = out_keep; pl = out_last;
      if (in_valid && in_ready) begin
        if (first_in < 0) first_in = cyc;
        n_in++;
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_keep.push_back(out_keep);
        got_last.push_back(out_last);
        last_out = cyc;
        if (out_last || (max_out > 0 && got_data.size() >= max_out)) done = 1'b1;
      end
      @(posedge clk);
    end
    check("completed", done, 1);
    if (max_out == 0) begin
      check("in_count", n_in, iw);
      check("out_count", got_data.size(), ow);
      for (int k = 0; k < got_data.size() && k < ow; k++) begin
        check($sformatf("data%0d", k), got_data[k], exp_word(off, len, k));
        check($sformatf("keep%0d", k), got_keep[k], exp_keep(len, k));
        check($sformatf("last%0d", k), got_last[k], (k == ow - 1));
      end
      if (span_exp > 0) check("throughput_span", last_out - first_in, span_exp);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("idle_out_valid", out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_cmd_ready", cmd_ready, 1);
      check("idle_in_ready", in_ready, 0);
    end
    $display("[TB] xfer off=%0d len=%0d in=%0d out=%0d", off, len, n_in, got_data.size());
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_cmd_ready"}, cmd_ready, 1);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_in_ready"}, in_ready, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_data"}, out_data, 0);
    check({pfx, "_out_keep"}, out_keep, 0);
    check({pfx, "_out_last"}, out_last, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_offset = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    run_xfer(0, 16, 100, 100, 0, 0, 1'b0);
    check("t1_word0", got_data[0], 64'h0706050403020100);
    check("t1_word1", got_data[1], 64'h0F0E0D0C0B0A0908);

    run_xfer(3, 8, 100, 100, 0, 0, 1'b0);
    check("t2_word0", got_data[0], 64'h0A09080706050403);

    run_xfer(5, 3, 100, 100, 0, 0, 1'b0);
    check("t3_word0", got_data[0], 64'h0000000000070605);
    check("t3_keep0", got_keep[0], 8'h07);

    run_xfer(7, 17, 100, 100, 0, 0, 1'b0);
    check("t4_word0", got_data[0], 64'h0E0D0C0B0A090807);
    check("t4_keep2", got_keep[2], 8'h01);

    run_xfer(2, 40, 60, 60, 0, 0, 1'b1);
    run_xfer(3, 64, 100, 100, 0, 9, 1'b1);

    // Zero-length command is accepted and dropped
    @(negedge clk);
    cmd_valid = 1'b1; cmd_offset = 3'd4; cmd_len = '0;
    #1;
    check("len0_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("len0_busy", busy, 0);

    for (int t = 0; t < 20; t++)
      run_xfer($urandom_range(7), $urandom_range(50, 1), $urandom_range(100, 40),
               $urandom_range(100, 40), 0, 0, 1'b1);

    // Reset mid-transfer after one of three output words
    run_xfer(2, 24, 100, 100, 1, 0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_values("midrst");
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_xfer(1, 7, 100, 100, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
